// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command parser: FSM states, ASCII codes,
// time-field limits and small character-classification helpers.
package uart_cmd_pkg;

    // Parser states: idle/single-char commands, collecting the six time
    // digits, and waiting for the terminating carriage return.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_WAIT_CR = 2'd2
    } state_t;

    // Command letters are stored upper case; lower case is folded before compare.
    localparam logic [7:0] CMD_RUN   = 8'h52;  // 'R'
    localparam logic [7:0] CMD_CLEAR = 8'h43;  // 'C'
    localparam logic [7:0] CMD_MODE  = 8'h4D;  // 'M'
    localparam logic [7:0] CMD_SET   = 8'h53;  // 'S'
    localparam logic [7:0] ASCII_CR  = 8'h0D;
    localparam logic [7:0] ASCII_LF  = 8'h0A;
    localparam logic [7:0] ASCII_0   = 8'h30;
    localparam logic [7:0] ASCII_9   = 8'h39;

    // Upper limits of the decoded time fields (centiseconds cannot exceed 99).
    localparam logic [6:0] MAX_MIN = 7'd59;
    localparam logic [6:0] MAX_SEC = 7'd59;

    // A set command carries MM SS CC: six decimal digits.
    localparam int         NUM_DIGITS = 6;
    localparam logic [2:0] LAST_DIGIT = 3'(NUM_DIGITS - 1);

    // Fold ASCII 'a'..'z' onto 'A'..'Z'; every other code passes unchanged.
    function automatic logic [7:0] to_upper(input logic [7:0] c);
        if ((c >= 8'h61) && (c <= 8'h7A)) begin
            return c - 8'h20;
        end
        return c;
    endfunction

    // True for ASCII '0'..'9'.
    function automatic logic is_digit(input logic [7:0] c);
        return (c >= ASCII_0) && (c <= ASCII_9);
    endfunction

endpackage

// File: rtl/uart_cmd_parser_bcd2_to_bin.sv
// Two BCD digits (tens, ones) to a 7-bit binary value. Purely combinational;
// tens*10 is formed as (t<<3)+(t<<1) so no multiplier is needed. Legal digit
// pairs (00..99) never overflow the 7-bit result.
module bcd2_to_bin (
    input  logic [3:0] i_tens,
    input  logic [3:0] i_ones,
    output logic [6:0] o_value
);

    logic [6:0] w_tens;
    logic [6:0] w_ones;

    assign w_tens  = {3'b000, i_tens};
    assign w_ones  = {3'b000, i_ones};
    assign o_value = (w_tens << 3) + (w_tens << 1) + w_ones;

endmodule

// File: rtl/uart_cmd_parser.sv
// UART command parser: turns received bytes into stopwatch control pulses
// (run/stop, clear, mode) and parses the "S MMSSCC <CR>" set-time command
// into range-checked minute/second/centisecond values. All outputs are
// registered and appear one cycle after the rx_done strobe that caused them.
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int TIMEOUT_MS = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    output logic       run_stop,
    output logic       clear,
    output logic       mode,
    output logic       set_valid,
    output logic [5:0] set_min,
    output logic [5:0] set_sec,
    output logic [6:0] set_cs,
    output logic       err,
    output logic       busy
);

    // Inter-byte timeout of a set command, in clock cycles.
    localparam int              TIMEOUT_CYC = CLK_HZ / 1000 * TIMEOUT_MS;
    localparam int              TO_W        = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_LAST     = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [TO_W-1:0] TO_ONE      = TO_W'(1);

    // FSM, digit store and timeout counter.
    state_t          r_state;
    logic [TO_W-1:0] r_to_cnt;
    logic [2:0]      r_digit_cnt;
    logic [5:0][3:0] r_digit;

    // Registered outputs.
    logic       r_run_stop;
    logic       r_clear;
    logic       r_mode;
    logic       r_set_valid;
    logic [5:0] r_set_min;
    logic [5:0] r_set_sec;
    logic [6:0] r_set_cs;
    logic       r_err;
    logic       r_busy;

    // Decode helpers.
    logic [7:0] w_byte_uc;
    logic [6:0] w_min;
    logic [6:0] w_sec;
    logic [6:0] w_cs;
    logic       w_time_ok;
    logic       w_timeout;

    assign w_byte_uc = to_upper(rx_data);
    assign w_timeout = (r_to_cnt == TO_LAST);
    assign w_time_ok = (w_min <= MAX_MIN) && (w_sec <= MAX_SEC);

    // Digit pairs on the wire are tens first: d0d1 = minutes, d2d3 = seconds,
    // d4d5 = centiseconds.
    bcd2_to_bin u_bcd_min (
        .i_tens  (r_digit[0]),
        .i_ones  (r_digit[1]),
        .o_value (w_min)
    );

    bcd2_to_bin u_bcd_sec (
        .i_tens  (r_digit[2]),
        .i_ones  (r_digit[3]),
        .o_value (w_sec)
    );

    bcd2_to_bin u_bcd_cs (
        .i_tens  (r_digit[4]),
        .i_ones  (r_digit[5]),
        .o_value (w_cs)
    );

    // Command FSM: byte decode, digit capture, timeout supervision and all
    // registered outputs. A byte arriving on the timeout terminal count wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_to_cnt    <= '0;
            r_digit_cnt <= '0;
            // NOTE: the digit store is only six nibbles, so it is reset
            // along with the control state; larger memories would not be.
            r_digit     <= '0;
            r_run_stop  <= 1'b0;
            r_clear     <= 1'b0;
            r_mode      <= 1'b0;
            r_set_valid <= 1'b0;
            r_set_min   <= '0;
            r_set_sec   <= '0;
            r_set_cs    <= '0;
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            // NOTE: pulses default low every cycle and are raised only by the
            // branch that needs them; non-blocking assignments make the last
            // write win without ordering hazards between the branches.
            r_run_stop  <= 1'b0;
            r_clear     <= 1'b0;
            r_mode      <= 1'b0;
            r_set_valid <= 1'b0;
            r_err       <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    r_to_cnt <= '0;
                    if (rx_done) begin
                        case (w_byte_uc)
                            CMD_RUN:   r_run_stop <= 1'b1;
                            CMD_CLEAR: r_clear    <= 1'b1;
                            CMD_MODE:  r_mode     <= 1'b1;
                            CMD_SET: begin
                                r_state     <= ST_COLLECT;
                                r_busy      <= 1'b1;
                                r_digit_cnt <= '0;
                            end
                            ASCII_CR, ASCII_LF: begin
                                // Line endings between commands are ignored.
                            end
                            default:   r_err      <= 1'b1;
                        endcase
                    end
                end

                ST_COLLECT: begin
                    if (rx_done) begin
                        r_to_cnt <= '0;
                        if (is_digit(rx_data)) begin
                            r_digit[r_digit_cnt] <= rx_data[3:0];
                            r_digit_cnt          <= r_digit_cnt + 3'd1;
                            if (r_digit_cnt == LAST_DIGIT) begin
                                r_state <= ST_WAIT_CR;
                            end
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else if (w_timeout) begin
                        r_err    <= 1'b1;
                        r_state  <= ST_IDLE;
                        r_busy   <= 1'b0;
                        r_to_cnt <= '0;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_ONE;
                    end
                end

                ST_WAIT_CR: begin
                    if (rx_done) begin
                        r_to_cnt <= '0;
                        r_state  <= ST_IDLE;
                        r_busy   <= 1'b0;
                        if ((rx_data == ASCII_CR) && w_time_ok) begin
                            r_set_min   <= w_min[5:0];
                            r_set_sec   <= w_sec[5:0];
                            r_set_cs    <= w_cs;
                            r_set_valid <= 1'b1;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end else if (w_timeout) begin
                        r_err    <= 1'b1;
                        r_state  <= ST_IDLE;
                        r_busy   <= 1'b0;
                        r_to_cnt <= '0;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_ONE;
                    end
                end

                default: begin
                    r_state  <= ST_IDLE;
                    r_busy   <= 1'b0;
                    r_to_cnt <= '0;
                end
            endcase
        end
    end

    assign run_stop  = r_run_stop;
    assign clear     = r_clear;
    assign mode      = r_mode;
    assign set_valid = r_set_valid;
    assign set_min   = r_set_min;
    assign set_sec   = r_set_sec;
    assign set_cs    = r_set_cs;
    assign err       = r_err;
    assign busy      = r_busy;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser. A string-level reference model
// (command buffer + decimal arithmetic) predicts the outputs that follow
// each received byte; directed scenarios cover the corner cases and a
// randomized command mix covers the rest.
module tb_uart_cmd_parser;

    localparam int CLK_HZ      = 10_000;
    localparam int TIMEOUT_MS  = 1;
    localparam int TIMEOUT_CYC = CLK_HZ / 1000 * TIMEOUT_MS;

    typedef struct packed {
        logic       run_stop;
        logic       clear;
        logic       mode;
        logic       set_valid;
        logic       err;
        logic       busy;
        logic [5:0] set_min;
        logic [5:0] set_sec;
        logic [6:0] set_cs;
    } out_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       run_stop;
    logic       clear;
    logic       mode;
    logic       set_valid;
    logic [5:0] set_min;
    logic [5:0] set_sec;
    logic [6:0] set_cs;
    logic       err;
    logic       busy;

    int checks = 0;
    int errors = 0;

    // Reference model state: inside a set command or not, the characters
    // received after 'S', and the last accepted time.
    bit         m_in_set;
    logic [7:0] m_buf[$];
    int         m_min;
    int         m_sec;
    int         m_cs;

    logic [7:0] singles[8] = '{8'h52, 8'h72, 8'h43, 8'h63, 8'h4D, 8'h6D, 8'h0D, 8'h0A};

    uart_cmd_parser #(
        .CLK_HZ     (CLK_HZ),
        .TIMEOUT_MS (TIMEOUT_MS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_done   (rx_done),
        .run_stop  (run_stop),
        .clear     (clear),
        .mode      (mode),
        .set_valid (set_valid),
        .set_min   (set_min),
        .set_sec   (set_sec),
        .set_cs    (set_cs),
        .err       (err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running (got no finish, expected finish)");
        $fatal(1);
    end

    function automatic out_t sample();
        out_t o;
        o.run_stop  = run_stop;
        o.clear     = clear;
        o.mode      = mode;
        o.set_valid = set_valid;
        o.err       = err;
        o.busy      = busy;
        o.set_min   = set_min;
        o.set_sec   = set_sec;
        o.set_cs    = set_cs;
        return o;
    endfunction

    function automatic void model_reset();
        m_in_set = 1'b0;
        m_buf.delete();
        m_min = 0;
        m_sec = 0;
        m_cs  = 0;
    endfunction

    // Expected outputs in the cycle after byte b is received.
    function automatic out_t model_byte(input logic [7:0] b);
        out_t e;
        int   mn;
        int   sc;
        int   cc;
        e = '0;
        if (!m_in_set) begin
            if (b == 8'h52 || b == 8'h72)      e.run_stop = 1'b1;
            else if (b == 8'h43 || b == 8'h63) e.clear    = 1'b1;
            else if (b == 8'h4D || b == 8'h6D) e.mode     = 1'b1;
            else if (b == 8'h53 || b == 8'h73) begin
                m_in_set = 1'b1;
                m_buf.delete();
            end else if (b == 8'h0D || b == 8'h0A) begin
                e.err = 1'b0;
            end else e.err = 1'b1;
        end else if (m_buf.size() < 6) begin
            if (b >= 8'h30 && b <= 8'h39) m_buf.push_back(b);
            else begin
                e.err    = 1'b1;
                m_in_set = 1'b0;
            end
        end else begin
            m_in_set = 1'b0;
            if (b == 8'h0D) begin
                mn = (int'(m_buf[0]) - 48) * 10 + (int'(m_buf[1]) - 48);
                sc = (int'(m_buf[2]) - 48) * 10 + (int'(m_buf[3]) - 48);
                cc = (int'(m_buf[4]) - 48) * 10 + (int'(m_buf[5]) - 48);
                if (mn <= 59 && sc <= 59) begin
                    m_min = mn;
                    m_sec = sc;
                    m_cs  = cc;
                    e.set_valid = 1'b1;
                end else e.err = 1'b1;
            end else e.err = 1'b1;
        end
        e.busy    = m_in_set;
        e.set_min = 6'(m_min);
        e.set_sec = 6'(m_sec);
        e.set_cs  = 7'(m_cs);
        return e;
    endfunction

    // All tasks start and end on a falling edge. Idle for n cycles with junk
    // on rx_data, counting cycles where any pulse output is high.
    task automatic idle(input int n, output int spur);
        out_t o;
        spur = 0;
        repeat (n) begin
            rx_data = 8'($urandom);
            @(negedge clk);
            o = sample();
            if (o.run_stop | o.clear | o.mode | o.set_valid | o.err) spur++;
        end
    endtask

    // Idle for gap cycles, strobe byte b for one cycle, return the outputs of
    // the following cycle.
    task automatic send(input logic [7:0] b, input int gap, output out_t obs, output int spur);
        idle(gap, spur);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
        rx_data = 8'($urandom);
        obs = sample();
    endtask

    task automatic test_reset();
        out_t o;
        rst     = 1'b1;
        rx_done = 1'b0;
        rx_data = 8'h00;
        model_reset();
        repeat (3) @(negedge clk);
        o = sample();
        checks++;
        if (o !== '0) begin
            $display("FAIL reset_held: got %h expected %h", o, out_t'('0));
            errors++;
        end
        rst = 1'b0;
        @(negedge clk);
        o = sample();
        checks++;
        if (o !== '0) begin
            $display("FAIL reset_released: got %h expected %h", o, out_t'('0));
            errors++;
        end
    endtask

    task automatic test_single();
        logic [7:0] cmds[3] = '{8'h72, 8'h43, 8'h6D};
        out_t o;
        out_t e;
        int   sp;
        for (int i = 0; i < 3; i++) begin
            send(cmds[i], 2, o, sp);
            e = model_byte(cmds[i]);
            checks++;
            if (o !== e || sp != 0) begin
                $display("FAIL single_cmd 0x%02h: got %h (spurious %0d) expected %h (spurious 0)", cmds[i], o, sp, e);
                errors++;
            end
        end
        idle(3, sp);
        checks++;
        if (sp != 0) begin
            $display("FAIL single_cmd_tail: got %0d extra pulses expected 0", sp);
            errors++;
        end
    endtask

    // Send a digit string prefixed by 'S' and followed by terminator t,
    // comparing every byte's outcome.
    task automatic test_set_string(input string tag, input string s, input logic [7:0] t, input int gap);
        out_t       o;
        out_t       e;
        int         sp;
        logic [7:0] b;
        for (int i = 0; i <= s.len(); i++) begin
            b = (i == s.len()) ? t : 8'(s[i]);
            send(b, gap, o, sp);
            e = model_byte(b);
            checks++;
            if (o !== e || sp != 0) begin
                $display("FAIL %s byte %0d (0x%02h): got %h (spurious %0d) expected %h (spurious 0)", tag, i, b, o, sp, e);
                errors++;
            end
        end
    endtask

    task automatic test_set_basic();
        test_set_string("set_012345", "S012345", 8'h0D, 1);
        checks++;
        if (set_min !== 6'd1 || set_sec !== 6'd23 || set_cs !== 7'd45) begin
            $display("FAIL set_basic_value: got %0d:%0d.%0d expected 1:23.45", set_min, set_sec, set_cs);
            errors++;
        end
    endtask

    task automatic test_range();
        test_set_string("set_605900", "S605900", 8'h0D, 0);
        test_set_string("set_006000", "s006000", 8'h0D, 0);
        test_set_string("set_595999", "S595999", 8'h0D, 0);
        checks++;
        if (set_min !== 6'd59 || set_sec !== 6'd59 || set_cs !== 7'd99) begin
            $display("FAIL set_max_value: got %0d:%0d.%0d expected 59:59.99", set_min, set_sec, set_cs);
            errors++;
        end
        test_set_string("set_bad_term", "S010101", 8'h0A, 1);
    endtask

    task automatic test_bad_digit();
        test_set_string("bad_digit", "S12", 8'h61, 1);
        test_set_string("recover_r", "", 8'h52, 1);
        test_set_string("idle_junk", "", 8'h7E, 0);
    endtask

    task automatic test_timeout();
        out_t o;
        int   err_seen;
        test_set_string("to_prefix", "S1", 8'h32, 1);
        // Last byte's strobe was cycle 0; we are sampling cycle 1. The
        // command aborts after TIMEOUT_CYC silent cycles, flagged one cycle later.
        err_seen = 0;
        for (int k = 2; k <= TIMEOUT_CYC + 5; k++) begin
            rx_data = 8'($urandom);
            @(negedge clk);
            o = sample();
            if (o.err) err_seen++;
            checks++;
            if (o.err !== (k == TIMEOUT_CYC + 1) || o.busy !== (k <= TIMEOUT_CYC)) begin
                $display("FAIL timeout_cycle %0d: got err=%b busy=%b expected err=%b busy=%b",
                         k, o.err, o.busy, (k == TIMEOUT_CYC + 1), (k <= TIMEOUT_CYC));
                errors++;
            end
        end
        checks++;
        if (err_seen != 1) begin
            $display("FAIL timeout_err_count: got %0d expected 1", err_seen);
            errors++;
        end
        m_in_set = 1'b0;
        m_buf.delete();
        // Every byte lands exactly on the last allowed cycle.
        test_set_string("terminal_count", "S034256", 8'h0D, TIMEOUT_CYC - 1);
    endtask

    task automatic test_reset_mid();
        out_t o;
        int   sp;
        test_set_string("pre_reset", "S012", 8'h33, 0);
        #2 rst = 1'b1;
        #1 o = sample();
        model_reset();
        checks++;
        if (o !== '0) begin
            $display("FAIL reset_mid: got %h expected %h", o, out_t'('0));
            errors++;
        end
        @(negedge clk);
        rst = 1'b0;
        idle(4, sp);
        o = sample();
        checks++;
        if (sp != 0 || o.busy !== 1'b0) begin
            $display("FAIL reset_mid_quiet: got spurious=%0d busy=%b expected 0 and 0", sp, o.busy);
            errors++;
        end
        test_set_string("set_000000", "S000000", 8'h0D, 0);
    endtask

    task automatic test_back_to_back();
        test_set_string("b2b_rcm", "rc", 8'h6D, 0);
        test_set_string("b2b_set", "S235917", 8'h0D, 0);
        test_set_string("b2b_after", "", 8'h4D, 0);
    endtask

    task automatic test_random();
        logic [7:0] q[$];
        out_t       o;
        out_t       e;
        int         sp;
        int         t;
        int         p;
        int         d;
        for (int n = 0; n < 80; n++) begin
            q.delete();
            t = $urandom_range(0, 9);
            if (t <= 3) begin
                q.push_back(singles[$urandom_range(0, 7)]);
            end else if (t <= 7) begin
                q.push_back(($urandom_range(0, 1) != 0) ? 8'h53 : 8'h73);
                for (int k = 0; k < 6; k++) begin
                    d = (k == 0 || k == 2) ? $urandom_range(0, 6) : $urandom_range(0, 9);
                    q.push_back(8'(8'h30 + d));
                end
                q.push_back(8'h0D);
                if (t == 7) begin
                    p = $urandom_range(1, 7);
                    q[p] = 8'($urandom);
                end
            end else if (t == 8) begin
                q.push_back(8'($urandom));
            end else begin
                q.push_back(8'h53);
                p = $urandom_range(0, 5);
                for (int k = 0; k < p; k++) q.push_back(8'(8'h30 + $urandom_range(0, 9)));
                q.push_back(8'h52);
            end
            for (int i = 0; i < q.size(); i++) begin
                send(q[i], $urandom_range(0, TIMEOUT_CYC - 1), o, sp);
                e = model_byte(q[i]);
                checks++;
                if (o !== e || sp != 0) begin
                    $display("FAIL random cmd %0d byte %0d (0x%02h): got %h (spurious %0d) expected %h (spurious 0)",
                             n, i, q[i], o, sp, e);
                    errors++;
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_set_basic();
        test_range();
        test_bad_digit();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
- Consumes the byte stream produced by the UART receiver (rx_data plus a 1-cycle rx_done strobe) and turns it into stopwatch control actions.
- Single-character commands become 1-cycle control pulses.
- One multi-byte "set time" command is parsed, range-checked and presented as a loadable time value.
- Sits between the UART receiver and the stopwatch control/datapath; all logic runs in the clk domain.

Parameters:
- CLK_HZ, 100_000_000, system clock frequency in Hz.
- TIMEOUT_MS, 1000, max gap between bytes of a set command before it is aborted.
- TIMEOUT_CYC, CLK_HZ/1000*TIMEOUT_MS (derived localparam), timeout in clk cycles; counter width $clog2(TIMEOUT_CYC+1).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- rx_data  in  8  received byte; valid only in the cycle rx_done=1
- rx_done  in  1  1-cycle strobe, one per received byte
- run_stop  out  1  1-cycle pulse: toggle run/stop
- clear  out  1  1-cycle pulse: clear stopwatch
- mode  out  1  1-cycle pulse: toggle display mode
- set_valid  out  1  1-cycle pulse: set_min/set_sec/set_cs carry a new valid time
- set_min  out  6  minutes 0..59; held until next set_valid
- set_sec  out  6  seconds 0..59; held until next set_valid
- set_cs  out  7  centiseconds 0..99; held until next set_valid
- err  out  1  1-cycle pulse: malformed, out-of-range or timed-out command
- busy  out  1  high while a set command is in progress (state != IDLE)

Behaviour:
- Reset (async, rst=1):
  - state=IDLE.
  - All pulses 0, busy=0.
  - set_min/set_sec/set_cs=0.
  - Digit registers and counters cleared.
  - A reset mid-command discards the partial command with no err.
- All outputs are registered. Any pulse caused by a byte asserts exactly 1 cycle after the rx_done cycle (latency 1). At most one pulse output is high per cycle.
- States: IDLE, COLLECT, WAIT_CR.
- IDLE, on rx_done:
  - 'R'/'r' (0x52/0x72) -> run_stop.
  - 'C'/'c' (0x43/0x63) -> clear.
  - 'M'/'m' (0x4D/0x6D) -> mode.
  - 'S'/'s' (0x53/0x73) -> COLLECT, digit_cnt=0, timeout counter=0.
  - 0x0D, 0x0A -> ignored, no pulse.
  - Any other byte -> err.
- COLLECT, on rx_done:
  - ASCII '0'..'9' (0x30..0x39): store rx_data[3:0] in digit[digit_cnt], digit_cnt+1. After the 6th digit (digit_cnt was 5) -> WAIT_CR.
  - Any other byte -> err, IDLE.
- WAIT_CR, on rx_done:
  - 0x0D: compute min=d0*10+d1, sec=d2*10+d3, cs=d4*10+d5.
    - If min<=59 and sec<=59 (cs is always <=99): load the set_* registers and pulse set_valid, -> IDLE.
    - Otherwise: err, set_* unchanged, -> IDLE.
  - Any other byte -> err, IDLE.
- Digit order on the wire: S M M S S C C CR (tens before ones). Example: "S012345\r" gives min=1, sec=23, cs=45.
- Timeout (COLLECT and WAIT_CR):
  - Counter increments every cycle without rx_done and resets to 0 on rx_done.
  - When it reaches TIMEOUT_CYC-1 without rx_done: err, -> IDLE.
  - If rx_done and the timeout terminal count fall in the same cycle, the byte wins: it is processed and the counter reset.
  - Counter is held at 0 in IDLE.
- set_* loading arithmetic: tens*10 computed as (t<<3)+(t<<1) in 7-bit width; no truncation for legal digits.
- rx_data is ignored whenever rx_done=0.

Decomposition:
- Shared package uart_cmd_pkg:
  - state encoding localparams.
  - ASCII code constants (CMD_RUN, CMD_CLEAR, CMD_MODE, CMD_SET, ASCII_CR, ASCII_LF, ASCII_0).
  - MAX_MIN=59, MAX_SEC=59.
- One natural sub-module: bcd2_to_bin (combinational, two 4-bit digits -> 7-bit value), instantiated three times.
- FSM, digit store and timeout counter stay in the top module.

Test Plan:
- Reset then send 'r', 'C', 'm' -> exactly one run_stop, clear, mode pulse each, 1 cycle after each rx_done; err never asserts.
- Send "S012345" + 0x0D -> set_valid 1 cycle after the CR strobe with set_min=1, set_sec=23, set_cs=45; busy high from 'S'+1 until the CR strobe+1.
- Send "S605900\r" -> err pulse, no set_valid, set_* keep their previous values. Then send "S595999\r" -> set_min=59, set_sec=59, set_cs=99.
- Send "S12a" -> err on 'a', state IDLE. A following 'R' -> run_stop (parser recovered).
- Send "S12", then idle TIMEOUT_CYC cycles (TIMEOUT_MS=1, CLK_HZ=10_000) -> single err pulse, busy falls. Separately, deliver a byte exactly at the terminal count -> no err, byte accepted.
- Assert rst mid-"S0123" -> busy=0, no err, no set_valid. After release, send "S000000\r" -> set_valid with all zeros.
